register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 62 ++++++
 tb/tb_register_file.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32 x XLEN register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Define REGISTER_FILE_DUMP_EN to print all registers on each rising edge of done (simulation only).
module register_file #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we3,
    input  logic [4:0]      a1,
    input  logic [4:0]      a2,
    input  logic [4:0]      a3,
    input  logic [XLEN-1:0] wd3,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            done
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we3 && (a3 != 5'd0)) begin
            regs[a3] <= wd3;
        end
    end

    // x0 is forced at the read mux so its storage slot never matters
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (a1 != 5'd0) rd1 = regs[a1];
        if (a2 != 5'd0) rd2 = regs[a2];
    end

`ifdef REGISTER_FILE_DUMP_EN
    logic done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done;
        end
    end

    // Nonblocking writes above have not landed yet, so this shows pre-edge contents
    always_ff @(posedge clk) begin
        if (done && !done_q) begin
            for (int unsigned i = 0; i < 32; i++) begin
                $display("x%0d = %h", i, (i == 0) ? {XLEN{1'b0}} : regs[i]);
            end
        end
    end
`else
    logic unused_done;
    assign unused_done = done;
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset sweep, read/write, x0, hold, reset priority.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic        we3;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        done;

    int unsigned total;
    int unsigned bad;

    register_file #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we3   (we3),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        we3   = 1'b0;
        a1    = 5'd0;
        a2    = 5'd0;
        a3    = 5'd0;
        wd3   = '0;
        done  = 1'b0;

        // reset held for two edges, then sweep every address on both ports
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1_x%0d", i), rd1, 32'h0);
            check($sformatf("reset_rd2_x%0d", 31 - i), rd2, 32'h0);
        end

        // write x1, no bypass before the edge
        we3 = 1'b1; a3 = 5'd1; wd3 = 32'h12345678; a1 = 5'd1; a2 = 5'd0;
        #1;
        check("no_bypass_x1", rd1, 32'h0);
        step();
        we3 = 1'b0;
        #1;
        check("write_x1", rd1, 32'h12345678);

        // write x2 through port 2
        we3 = 1'b1; a3 = 5'd2; wd3 = 32'h87654321; a2 = 5'd2;
        #1;
        check("no_bypass_x2", rd2, 32'h0);
        step();
        we3 = 1'b0;
        #1;
        check("write_x2_rd2", rd2, 32'h87654321);
        check("x1_still_rd1", rd1, 32'h12345678);

        // both ports on the same address
        a1 = 5'd2; a2 = 5'd2;
        #1;
        check("same_addr_rd1", rd1, 32'h87654321);
        check("same_addr_rd2", rd2, 32'h87654321);

        // write to x0 is dropped
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'hDEADBEEF;
        step();
        we3 = 1'b0; a1 = 5'd0; a2 = 5'd0;
        #1;
        check("x0_rd1", rd1, 32'h0);
        check("x0_rd2", rd2, 32'h0);
        a1 = 5'd1; a2 = 5'd2;
        #1;
        check("x0_wr_x1_kept", rd1, 32'h12345678);
        check("x0_wr_x2_kept", rd2, 32'h87654321);

        // top address
        we3 = 1'b1; a3 = 5'd31; wd3 = 32'hCAFEF00D;
        step();
        we3 = 1'b0; a2 = 5'd31;
        #1;
        check("write_x31", rd2, 32'hCAFEF00D);
        check("x31_wr_x1_kept", rd1, 32'h12345678);

        // hold with we3 low
        we3 = 1'b0; a3 = 5'd1; wd3 = 32'hFFFFFFFF; a1 = 5'd1;
        step();
        check("hold_x1", rd1, 32'h12345678);

        // done pulse held three edges: exercises the dump path, state untouched
        done = 1'b1;
        step();
        step();
        step();
        done = 1'b0;
        a2 = 5'd2;
        #1;
        check("after_done_x1", rd1, 32'h12345678);
        check("after_done_x2", rd2, 32'h87654321);

        // reset beats a simultaneous write
        rst_n = 1'b0; we3 = 1'b1; a3 = 5'd5; wd3 = 32'hA5A5A5A5;
        step();
        rst_n = 1'b1; we3 = 1'b0;
        a1 = 5'd1; a2 = 5'd2;
        #1;
        check("rst_x1", rd1, 32'h0);
        check("rst_x2", rd2, 32'h0);
        a1 = 5'd5; a2 = 5'd31;
        #1;
        check("rst_x5", rd1, 32'h0);
        check("rst_x31", rd2, 32'h0);

        // writes work again after reset
        we3 = 1'b1; a3 = 5'd5; wd3 = 32'h0F0F1234;
        step();
        we3 = 1'b0;
        #1;
        check("post_rst_x5", rd1, 32'h0F0F1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
